kt_job_ctrl: RTL and testbench
==============================

Name: kt_job_ctrl

Overview:
- Sequencer between the pad-side input/output pins and the KT (knight's tour) core.
- Captures one input pattern burst into a local buffer, then replays it to the core as a clean contiguous burst.
- Supervises the core's run with a watchdog timer, then forwards the core's result stream to the output pins through one register stage.
- Provides the chip with a defined busy indication and a recovery path when the core hangs.

Parameters:
MAX_MOVES, 25, depth of the coordinate buffer (5x5 board); extra beats are dropped.
TIMEOUT, 3000, maximum cycles in WAIT before a timeout is declared.
TW, 12, width of the watchdog counter; must satisfy 2^TW > TIMEOUT.

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
in_valid  in  1  host burst valid
in_x  in  3  host x coordinate
in_y  in  3  host y coordinate
move_num  in  5  move count, sampled on first beat only
priority_num  in  3  priority, sampled on first beat only
core_in_valid  out  1  replay burst valid to core
core_in_x  out  3  replayed x
core_in_y  out  3  replayed y
core_move_num  out  5  captured move_num on first replay beat, 0 otherwise
core_priority_num  out  3  captured priority on first replay beat, 0 otherwise
core_out_valid  in  1  core result valid
core_out_x  in  3  core result x
core_out_y  in  3  core result y
core_move_out  in  5  core result step index
out_valid  out  1  result valid to pads
out_x  out  3  result x
out_y  out  3  result y
move_out  out  5  result step index
busy  out  1  high whenever state != IDLE
timeout_err  out  1  one-cycle pulse on watchdog expiry

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state = IDLE; wr_ptr, rd_ptr, timer and beat counter = 0; every output = 0. Asserting rst in any state aborts the job and takes effect at the next clk edge.
- States: IDLE, LOAD, LAUNCH, WAIT, DRAIN, ERR.
- IDLE:
  - in_valid = 1 captures move_num and priority_num, writes buf[0] = {in_x, in_y}, sets wr_ptr = 1, goes to LOAD.
- LOAD:
  - Each cycle with in_valid = 1 writes buf[wr_ptr] and increments wr_ptr.
  - Once wr_ptr = MAX_MOVES, further beats are dropped and wr_ptr saturates.
  - First cycle with in_valid = 0 goes to LAUNCH, with cnt = wr_ptr.
  - A one-beat burst therefore spends exactly one cycle in LOAD.
- LAUNCH:
  - Starting the cycle after entry, core_in_valid = 1 for exactly cnt consecutive cycles, presenting buf[0..cnt-1] in order.
  - core_move_num and core_priority_num are nonzero only on beat 0.
  - After the last beat, core_in_valid drops, timer clears, state goes to WAIT.
- WAIT:
  - timer increments every cycle.
  - core_out_valid = 1 goes to DRAIN, and that same beat is forwarded.
  - If timer = TIMEOUT-1 with no core_out_valid, go to ERR.
  - If core_out_valid arrives in the same cycle as expiry, core_out_valid wins.
- DRAIN:
  - Registered pass-through, latency 1 cycle. out_valid/out_x/out_y/move_out at cycle t+1 equal core_out_* at cycle t.
  - Beat counter increments per forwarded beat. Beats beyond MAX_MOVES are not forwarded (out_valid = 0).
  - First cycle with core_out_valid = 0 goes to IDLE. out_valid is 0 in that cycle's registered output.
- ERR (one cycle):
  - timeout_err = 1.
  - One out_valid beat with out_x = out_y = 0, move_out = 0.
  - Next state is IDLE.
- General rules:
  - out_* hold 0 whenever out_valid = 0. core_in_* hold 0 whenever core_in_valid = 0.
  - in_valid outside IDLE/LOAD is ignored; no buffer write and no state change.
  - core_out_valid outside WAIT/DRAIN is ignored.
  - No arithmetic wrap: wr_ptr, beat counter and timer all saturate.

Test Plan:
- Reset held 3 cycles mid-LAUNCH -> next cycle: state IDLE, busy = 0, core_in_valid = 0, all outputs 0.
- Burst move_num = 3, priority = 5, coords (0,0), (1,2), (2,4) -> core_in_valid high 3 cycles starting 2 cycles after in_valid falls; beat 0 carries move_num = 3, priority = 5; coords replayed in order.
- Core returns 25 beats, move_out 1..25 -> out_valid high 25 cycles, each 1 cycle delayed, values identical; busy falls the cycle after the last beat.
- Host burst of 30 beats -> exactly 25 replayed (buf[0..24]); the 5 extra are dropped.
- Core silent after launch -> timeout_err pulses at cycle TIMEOUT of WAIT; one out_valid beat with 0,0,0; state IDLE.
- in_valid pulsed during WAIT, then core responds -> pulse ignored; result forwarded normally; buffer unchanged.

Source files
------------

// File: rtl/kt_job_ctrl.sv
// kt_job_ctrl: buffers one host move burst, replays it to the KT core, watchdogs
// the core run and forwards its result stream to the pads through one register stage.
module kt_job_ctrl #(
  parameter int MAX_MOVES = 25,
  parameter int TIMEOUT = 3000,
  parameter int TW = 12
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_x,
  input  logic [2:0] in_y,
  input  logic [4:0] move_num,
  input  logic [2:0] priority_num,
  output logic       core_in_valid,
  output logic [2:0] core_in_x,
  output logic [2:0] core_in_y,
  output logic [4:0] core_move_num,
  output logic [2:0] core_priority_num,
  input  logic       core_out_valid,
  input  logic [2:0] core_out_x,
  input  logic [2:0] core_out_y,
  input  logic [4:0] core_move_out,
  output logic       out_valid,
  output logic [2:0] out_x,
  output logic [2:0] out_y,
  output logic [4:0] move_out,
  output logic       busy,
  output logic       timeout_err
);
  localparam int PW = $clog2(MAX_MOVES + 1);
  localparam logic [PW-1:0] MAXP = PW'(MAX_MOVES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LOAD, LAUNCH, WAIT, DRAIN, ERR} state_t;
  state_t state_q, state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, beat_q, beat_d, wr_idx;
  logic [TW-1:0] timer_q, timer_d;
  logic [4:0] mv_q, mv_d, cmv_q, cmv_d, mo_q, mo_d;
  logic [2:0] pr_q, pr_d, cpr_q, cpr_d;
  logic [5:0] cixy_q, cixy_d, oxy_q, oxy_d;
  logic [5:0] buf_q [MAX_MOVES];
  logic civ_q, civ_d, ov_q, ov_d, te_q, te_d, wr_en, fwd;

  assign wr_idx = (state_q == IDLE) ? '0 : wr_ptr_q;

  always_comb begin
    state_d = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = '0;
    beat_d = beat_q;
    timer_d = timer_q;
    mv_d = mv_q;
    pr_d = pr_q;
    wr_en = 1'b0;
    fwd = 1'b0;
    civ_d = 1'b0;
    cixy_d = '0;
    cmv_d = '0;
    cpr_d = '0;
    ov_d = 1'b0;
    oxy_d = '0;
    mo_d = '0;
    te_d = 1'b0;
    case (state_q)
      IDLE: if (in_valid) begin
        mv_d = move_num;
        pr_d = priority_num;
        wr_en = 1'b1;
        wr_ptr_d = PW'(1);
        state_d = LOAD;
      end
      LOAD: if (!in_valid) state_d = LAUNCH;
      else if (wr_ptr_q < MAXP) begin
        wr_en = 1'b1;
        wr_ptr_d = wr_ptr_q + 1'b1;
      end
      LAUNCH: if (rd_ptr_q < wr_ptr_q) begin
        civ_d = 1'b1;
        cixy_d = buf_q[rd_ptr_q];
        cmv_d = (rd_ptr_q == '0) ? mv_q : '0;
        cpr_d = (rd_ptr_q == '0) ? pr_q : '0;
        rd_ptr_d = rd_ptr_q + 1'b1;
      end else begin
        state_d = WAIT;
        timer_d = '0;
        beat_d = '0;
      end
      WAIT: begin
        timer_d = (timer_q == '1) ? timer_q : timer_q + 1'b1;
        fwd = core_out_valid;
        // A result arriving on the expiry cycle still counts as a response
        state_d = core_out_valid ? DRAIN : (timer_q == TLAST) ? ERR : WAIT;
        ov_d = !core_out_valid && timer_q == TLAST;
        te_d = ov_d;
      end
      DRAIN: begin
        fwd = core_out_valid;
        state_d = core_out_valid ? DRAIN : IDLE;
      end
      ERR: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (fwd && beat_q < MAXP) begin
      ov_d = 1'b1;
      oxy_d = {core_out_x, core_out_y};
      mo_d = core_move_out;
      beat_d = beat_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      beat_q <= '0;
      timer_q <= '0;
      mv_q <= '0;
      pr_q <= '0;
      civ_q <= 1'b0;
      cixy_q <= '0;
      cmv_q <= '0;
      cpr_q <= '0;
      ov_q <= 1'b0;
      oxy_q <= '0;
      mo_q <= '0;
      te_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      beat_q <= beat_d;
      timer_q <= timer_d;
      mv_q <= mv_d;
      pr_q <= pr_d;
      civ_q <= civ_d;
      cixy_q <= cixy_d;
      cmv_q <= cmv_d;
      cpr_q <= cpr_d;
      ov_q <= ov_d;
      oxy_q <= oxy_d;
      mo_q <= mo_d;
      te_q <= te_d;
    end
  end

  always_ff @(posedge clk) if (wr_en && !rst) buf_q[wr_idx] <= {in_x, in_y};

  assign core_in_valid = civ_q;
  assign {core_in_x, core_in_y} = cixy_q;
  assign core_move_num = cmv_q;
  assign core_priority_num = cpr_q;
  assign out_valid = ov_q;
  assign {out_x, out_y} = oxy_q;
  assign move_out = mo_q;
  assign timeout_err = te_q;
  assign busy = state_q != IDLE;
endmodule

// File: tb/tb_kt_job_ctrl.sv
// tb_kt_job_ctrl: job-level reference model of kt_job_ctrl with table and random jobs.
module tb_kt_job_ctrl;
  localparam int MAXM = 25;
  localparam int TO = 3000;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, core_out_valid = 1'b0;
  logic [2:0] in_x = '0, in_y = '0, priority_num = '0, core_out_x = '0, core_out_y = '0;
  logic [4:0] move_num = '0, core_move_out = '0;
  logic core_in_valid, out_valid, busy, timeout_err;
  logic [2:0] core_in_x, core_in_y, core_priority_num, out_x, out_y;
  logic [4:0] core_move_num, move_out;
  typedef struct packed {logic [31:0] c; logic [5:0] xy; logic [4:0] m; logic [2:0] p;} ci_t;
  typedef struct packed {logic [31:0] c; logic [5:0] xy; logic [4:0] m; logic te;} ob_t;
  typedef struct {int n, mv, pr, d, k, pulse, eci, eout, eto;} vec_t;
  ci_t ci_log[$];
  ob_t ob_log[$];
  vec_t tbl[6];
  int cyc = 0, errors = 0, checks = 0, te_cnt = 0, fall_cyc = -1;
  logic busy_d = 1'b0;

  kt_job_ctrl #(.MAX_MOVES(MAXM), .TIMEOUT(TO), .TW(12)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_x(in_x), .in_y(in_y),
    .move_num(move_num), .priority_num(priority_num),
    .core_in_valid(core_in_valid), .core_in_x(core_in_x), .core_in_y(core_in_y),
    .core_move_num(core_move_num), .core_priority_num(core_priority_num),
    .core_out_valid(core_out_valid), .core_out_x(core_out_x), .core_out_y(core_out_y),
    .core_move_out(core_move_out), .out_valid(out_valid), .out_x(out_x), .out_y(out_y),
    .move_out(move_out), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (core_in_valid) ci_log.push_back('{32'(cyc), {core_in_x, core_in_y}, core_move_num, core_priority_num});
    else chk("core_in_idle", 64'({core_in_x, core_in_y, core_move_num, core_priority_num}), 64'd0);
    if (out_valid) ob_log.push_back('{32'(cyc), {out_x, out_y}, move_out, timeout_err});
    else chk("out_idle", 64'({out_x, out_y, move_out, timeout_err}), 64'd0);
    if (timeout_err) te_cnt++;
    if (busy_d && !busy) fall_cyc = cyc;
    busy_d = busy;
  end

  task automatic run_job(input int n, mv, pr, d, k, pulse, eci, eout, eto, input bit rnd);
    logic [5:0] crd[$];
    logic [10:0] res[$];
    int m, kk, t_fall, w, end_c;
    bit to;
    ci_t ec;
    ob_t eo;
    ci_log.delete();
    ob_log.delete();
    te_cnt = 0;
    fall_cyc = -1;
    for (int i = 0; i < n; i++) begin
      crd.push_back(rnd ? 6'($urandom) : {3'(i), 3'(2 * i)});
      in_valid = 1'b1;
      {in_x, in_y} = crd[i];
      move_num = (i == 0) ? 5'(mv) : 5'($urandom);
      priority_num = (i == 0) ? 3'(pr) : 3'($urandom);
      tick();
    end
    in_valid = 1'b0;
    {in_x, in_y, move_num, priority_num} = '0;
    m = (n < MAXM) ? n : MAXM;
    kk = (k < MAXM) ? k : MAXM;
    for (int i = 0; i < k; i++) res.push_back({3'($urandom), 3'($urandom), 5'(i + 1)});
    to = (k == 0) || (d >= TO);
    t_fall = cyc;
    w = t_fall + 2 + m;
    end_c = to ? w + TO + 1 : w + d + k + 1;
    if (w + d + k + 1 > end_c) end_c = w + d + k + 1;
    while (cyc < end_c + 2) begin
      if (cyc >= w + d && cyc < w + d + k) begin
        core_out_valid = 1'b1;
        {core_out_x, core_out_y, core_move_out} = res[cyc - w - d];
      end else {core_out_valid, core_out_x, core_out_y, core_move_out} = '0;
      in_valid = (pulse != 0) && (cyc == w + 1);
      {in_x, in_y, move_num, priority_num} = in_valid ? 14'h3fff : 14'h0;
      tick();
    end
    chk("replay_count", 64'(ci_log.size()), 64'(eci));
    for (int i = 0; i < ci_log.size() && i < m; i++) begin
      ec = '{32'(t_fall + 2 + i), crd[i], (i == 0) ? 5'(mv) : 5'd0, (i == 0) ? 3'(pr) : 3'd0};
      chk($sformatf("replay_beat%0d", i), 64'(ci_log[i]), 64'(ec));
    end
    chk("out_count", 64'(ob_log.size()), 64'(eout));
    for (int i = 0; i < ob_log.size() && i < (to ? 1 : kk); i++) begin
      eo = to ? '{32'(w + TO), 6'd0, 5'd0, 1'b1} : '{32'(w + d + 1 + i), res[i][10:5], res[i][4:0], 1'b0};
      chk($sformatf("out_beat%0d", i), 64'(ob_log[i]), 64'(eo));
    end
    chk("timeout_pulses", 64'(te_cnt), 64'(eto));
    chk("busy_fall", 64'(fall_cyc), 64'(to ? w + TO + 1 : w + d + k + 1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n, d, k;
    tbl[0] = '{3, 3, 5, 4, 25, 0, 3, 25, 0};
    tbl[1] = '{30, 25, 7, 0, 30, 0, 25, 25, 0};
    tbl[2] = '{1, 1, 1, TO - 1, 2, 0, 1, 2, 0};
    tbl[3] = '{5, 9, 2, TO, 0, 0, 5, 1, 1};
    tbl[4] = '{4, 17, 6, 5, 3, 1, 4, 3, 0};
    tbl[5] = '{2, 31, 3, TO, 3, 1, 2, 1, 1};
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_outs", 64'({core_in_valid, core_in_x, core_in_y, core_move_num, core_priority_num,
                           out_valid, out_x, out_y, move_out, timeout_err}), 64'd0);
    run_job(tbl[0].n, tbl[0].mv, tbl[0].pr, tbl[0].d, tbl[0].k, tbl[0].pulse,
            tbl[0].eci, tbl[0].eout, tbl[0].eto, 1'b0);
    for (int i = 0; i < 25; i++) begin
      in_valid = 1'b1;
      {in_x, in_y, move_num, priority_num} = 14'($urandom);
      tick();
    end
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      chk("midrun_reset_busy", 64'(busy), 64'd0);
      chk("midrun_reset_outs", 64'({core_in_valid, core_in_x, core_in_y, core_move_num, core_priority_num,
                                    out_valid, out_x, out_y, move_out, timeout_err}), 64'd0);
      tick();
    end
    for (int i = 1; i < 6; i++)
      run_job(tbl[i].n, tbl[i].mv, tbl[i].pr, tbl[i].d, tbl[i].k, tbl[i].pulse,
              tbl[i].eci, tbl[i].eout, tbl[i].eto, 1'b0);
    for (int j = 0; j < 15; j++) begin
      n = $urandom_range(1, 30);
      d = $urandom_range(0, 30);
      k = $urandom_range(1, 30);
      run_job(n, $urandom_range(0, 31), $urandom_range(0, 7), d, k, $urandom_range(0, 1),
              (n < MAXM) ? n : MAXM, (k < MAXM) ? k : MAXM, 0, 1'b1);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
